arb_mux: RTL and testbench

//  - N-channel, WIDTH-bit arbitrating multiplexer with valid/ready handshake on every input and on the output.
//  - Successor to the fixed 2/3/4-way select muxes: the select is generated internally by a fixed-priority or round-robin arbiter.
//  - Result is held in a one-entry registered output stage.
//  - Used where several CPU units (fetch, load/store, DMA) share one downstream bus or write port.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/arb_mux.sv | 97 +++++++++
 tb/tb_arb_mux.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg : shared constants for CPU-side interconnect blocks
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter : combinational fixed-priority / round-robin grant generator
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import cpu_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int ARB_MODE = ARB_RR,
  localparam int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] start;
  logic [SEL_W:0]   cand;
  logic             found;

  // Fixed priority is a round-robin search that always starts at channel 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    start     = (ARB_MODE == ARB_RR) ? ptr : '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, start} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(N)) begin
        cand = cand - (SEL_W+1)'(N);
      end
      if (!found && req[cand[SEL_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[SEL_W-1:0]]  = 1'b1;
        grant_idx               = cand[SEL_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux : N-channel arbitrating mux with valid/ready and a registered output
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module arb_mux
  import cpu_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int N        = 4,
  parameter  int ARB_MODE = ARB_RR,
  localparam int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic             load_en;
  logic             accept;

  rr_arbiter #(
    .N        (N),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // out_ready feeds in_ready combinationally so a draining register refills with no bubble.
  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = rst_n ? (grant & {N{load_en}}) : '0;
  assign accept   = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = grant_idx;
      if (ARB_MODE == ARB_RR) begin
        ptr_d = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_arb_mux : directed vectors and a randomized scoreboard for arb_mux
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_arb_mux;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N=4 round-robin
  logic [3:0]   r4_valid, r4_ready;
  logic [127:0] r4_data;
  logic         r4_ov, r4_oready;
  logic [31:0]  r4_od;
  logic [1:0]   r4_os;
  // N=4 fixed priority
  logic [3:0]   f4_valid, f4_ready;
  logic [127:0] f4_data;
  logic         f4_ov, f4_oready;
  logic [31:0]  f4_od;
  logic [1:0]   f4_os;
  // N=3 round-robin (scoreboard)
  logic [2:0]   r3_valid, r3_ready;
  logic [95:0]  r3_data;
  logic         r3_ov, r3_oready;
  logic [31:0]  r3_od;
  logic [1:0]   r3_os;
  // N=1 passthrough
  logic [0:0]   n1_valid, n1_ready;
  logic [31:0]  n1_data;
  logic         n1_ov, n1_oready;
  logic [31:0]  n1_od;
  logic [0:0]   n1_os;

  arb_mux #(.WIDTH(32), .N(4), .ARB_MODE(ARB_RR)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_valid(r4_valid), .in_data(r4_data), .in_ready(r4_ready),
    .out_valid(r4_ov), .out_data(r4_od), .out_sel(r4_os), .out_ready(r4_oready));
  arb_mux #(.WIDTH(32), .N(4), .ARB_MODE(ARB_FIXED)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_valid(f4_valid), .in_data(f4_data), .in_ready(f4_ready),
    .out_valid(f4_ov), .out_data(f4_od), .out_sel(f4_os), .out_ready(f4_oready));
  arb_mux #(.WIDTH(32), .N(3), .ARB_MODE(ARB_RR)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_valid(r3_valid), .in_data(r3_data), .in_ready(r3_ready),
    .out_valid(r3_ov), .out_data(r3_od), .out_sel(r3_os), .out_ready(r3_oready));
  arb_mux #(.WIDTH(32), .N(1), .ARB_MODE(ARB_RR)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(n1_valid), .in_data(n1_data), .in_ready(n1_ready),
    .out_valid(n1_ov), .out_data(n1_od), .out_sel(n1_os), .out_ready(n1_oready));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference arbiter: first requester at or after p, wrapping over n channels.
  function automatic logic [3:0] pick(input logic [3:0] v, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return 4'(1) << ((p + k) % n);
    end
    return 4'b0000;
  endfunction

  typedef struct {
    logic [3:0]  valid;
    logic        rdy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[13];

  // scoreboard model state
  logic        m_ov, n_ov;
  logic [31:0] m_od, n_od;
  int          m_os, n_os, m_ptr, n_ptr;
  logic [3:0]  g4;
  logic [2:0]  exp_ir, acc_act;
  int          beats_model, beats_dut;

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA000_0000};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA000_0001};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA000_0002};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA000_0003};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA000_0000};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA000_0002};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA000_0000};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA000_0002};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA000_0002};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 32'hA000_0002};
    tbl[10] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA000_0003};
    tbl[11] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA000_0003};
    tbl[12] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA000_0000};

    rst_n = 1'b0;
    r4_valid = 4'b1111; r4_oready = 1'b0;
    f4_valid = '0; f4_oready = 1'b0;
    r3_valid = '0; r3_oready = 1'b0; r3_data = '0;
    n1_valid = '0; n1_oready = 1'b0; n1_data = '0;
    for (int i = 0; i < 4; i++) begin
      r4_data[i*32 +: 32] = 32'hA000_0000 | 32'(i);
      f4_data[i*32 +: 32] = 32'hB000_0000 | 32'(i);
    end

    // reset values, and in_ready held low while in reset even with requests
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(r4_ov), 32'd0);
    check("rst_out_data", r4_od, 32'd0);
    check("rst_out_sel", 32'(r4_os), 32'd0);
    check("rst_in_ready", 32'(r4_ready), 32'd0);
    r4_valid = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      r4_valid  = tbl[i].valid;
      r4_oready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(r4_ready), 32'(tbl[i].exp_ir));
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), 32'(r4_ov), 32'(tbl[i].exp_ov));
      check($sformatf("vec%0d_out_sel", i), 32'(r4_os), 32'(tbl[i].exp_sel));
      check($sformatf("vec%0d_out_data", i), r4_od, tbl[i].exp_data);
    end

    // backpressure: DEAD_BEEF held for 5 stalled cycles
    r4_data[63:32] = 32'hDEAD_BEEF; r4_valid = 4'b0010; r4_oready = 1'b1;
    @(negedge clk);
    check("bp_load_ready", 32'(r4_ready), 32'b0010);
    @(posedge clk); #1;
    check("bp_load_data", r4_od, 32'hDEAD_BEEF);
    r4_data[95:64] = 32'h1234_5678; r4_valid = 4'b0100; r4_oready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_stall_ready", 32'(r4_ready), 32'd0);
      check("bp_stall_data", r4_od, 32'hDEAD_BEEF);
      check("bp_stall_valid", 32'(r4_ov), 32'd1);
      @(posedge clk); #1;
    end
    r4_oready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(r4_ready), 32'b0100);
    @(posedge clk); #1;
    check("bp_next_data", r4_od, 32'h1234_5678);
    check("bp_next_sel", 32'(r4_os), 32'd2);

    // asynchronous reset with a full output register, ptr left at 3
    r4_valid = 4'b1111; r4_oready = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(r4_ov), 32'd0);
    check("midrst_out_data", r4_od, 32'd0);
    check("midrst_in_ready", 32'(r4_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; r4_oready = 1'b1;
    #1;
    check("postrst_in_ready", 32'(r4_ready), 32'b0001);
    @(posedge clk); #1;
    check("postrst_sel", 32'(r4_os), 32'd0);
    check("postrst_data", r4_od, 32'hA000_0000);
    r4_valid = 4'b0000;

    // fixed priority
    f4_valid = 4'b1010; f4_oready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("fp_ready_ch1", 32'(f4_ready), 32'b0010);
      @(posedge clk); #1;
      check("fp_sel_ch1", 32'(f4_os), 32'd1);
      check("fp_data_ch1", f4_od, 32'hB000_0001);
    end
    f4_valid = 4'b1000;
    @(negedge clk);
    check("fp_ready_ch3", 32'(f4_ready), 32'b1000);
    @(posedge clk); #1;
    check("fp_sel_ch3", 32'(f4_os), 32'd3);
    f4_valid = 4'b1111; f4_oready = 1'b0;
    @(negedge clk);
    check("fp_stall_ready", 32'(f4_ready), 32'd0);
    @(posedge clk); #1;
    f4_oready = 1'b1;
    @(negedge clk);
    check("fp_all_ready", 32'(f4_ready), 32'b0001);
    @(posedge clk); #1;
    check("fp_all_sel", 32'(f4_os), 32'd0);
    f4_valid = 4'b0000;

    // N=1 passthrough
    n1_valid = 1'b1; n1_data = 32'hCAFE_F00D; n1_oready = 1'b0;
    @(negedge clk);
    check("n1_ready_empty", 32'(n1_ready), 32'd1);
    @(posedge clk); #1;
    check("n1_valid", 32'(n1_ov), 32'd1);
    check("n1_data", n1_od, 32'hCAFE_F00D);
    check("n1_sel", 32'(n1_os), 32'd0);
    n1_data = 32'h1111_2222;
    @(negedge clk);
    check("n1_ready_full", 32'(n1_ready), 32'd0);
    @(posedge clk); #1;
    check("n1_hold_data", n1_od, 32'hCAFE_F00D);
    n1_oready = 1'b1;
    @(negedge clk);
    check("n1_ready_drain", 32'(n1_ready), 32'd1);
    @(posedge clk); #1;
    check("n1_next_data", n1_od, 32'h1111_2222);
    n1_valid = 1'b0;
    @(posedge clk); #1;
    check("n1_drained", 32'(n1_ov), 32'd0);

    // randomized scoreboard on N=3
    m_ov = 1'b0; m_od = '0; m_os = 0; m_ptr = 0;
    beats_model = 0; beats_dut = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      g4     = pick({1'b0, r3_valid}, m_ptr, 3);
      exp_ir = (!m_ov || r3_oready) ? g4[2:0] : 3'b000;
      check("sb_in_ready", 32'(r3_ready), 32'(exp_ir));
      check("sb_out_valid", 32'(r3_ov), 32'(m_ov));
      if (m_ov) begin
        check("sb_out_data", r3_od, m_od);
        check("sb_out_sel", 32'(r3_os), 32'(m_os));
      end
      n_ov = m_ov; n_od = m_od; n_os = m_os; n_ptr = m_ptr;
      if (exp_ir != 3'b000) begin
        for (int g = 0; g < 3; g++) begin
          if (exp_ir[g]) begin
            n_ov = 1'b1; n_od = r3_data[g*32 +: 32]; n_os = g;
            n_ptr = (g == 2) ? 0 : g + 1;
          end
        end
        beats_model++;
      end else if (m_ov && r3_oready) begin
        n_ov = 1'b0;
      end
      acc_act = r3_valid & r3_ready;
      if (acc_act != 3'b000) beats_dut++;
      @(posedge clk); #1;
      m_ov = n_ov; m_od = n_od; m_os = n_os; m_ptr = n_ptr;
      for (int i = 0; i < 3; i++) begin
        if (!r3_valid[i] || acc_act[i]) begin
          r3_valid[i] = ($urandom_range(0, 1) == 1);
          r3_data[i*32 +: 32] = $urandom();
        end
      end
      r3_oready = ($urandom_range(0, 3) != 0);
    end
    check("sb_beat_count", 32'(beats_dut), 32'(beats_model));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
